// File: rtl/request_conditioner_if.sv
// Request-conditioner bus: raw buttons/sensors and controller feedback in, clean
// pedestrian/vehicle request levels out.
interface request_conditioner_if;
  logic [3:0] braw_62;
  logic [1:0] iraw_62;
  logic [3:0] w_62;
  logic [1:0] g_62;
  logic [3:0] b_62;
  logic [1:0] i_62;
  logic [3:0] press_62;
  logic [2:0] pend_cnt_62;

  modport master (
    output braw_62, iraw_62, w_62, g_62,
    input  b_62, i_62, press_62, pend_cnt_62
  );

  modport slave (
    input  braw_62, iraw_62, w_62, g_62,
    output b_62, i_62, press_62, pend_cnt_62
  );
endinterface

// File: rtl/request_conditioner.sv
// Synchronises, debounces and latches pedestrian buttons and vehicle sensors for the
// traffic light controller. Optional vehicle-request expiry: define REQ_EXPIRE_EN.
module request_conditioner #(
  parameter int DB_CYCLES     = 4,
  parameter int CNT_W         = 3,
  parameter int EXPIRE_CYCLES = 16
) (
  input  logic                  clk_62,
  input  logic                  rst_62,
  request_conditioner_if.slave  bus
);

  localparam int NPED = 4;
  localparam int NVEH = 2;
  localparam int NCH  = NPED + NVEH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } db_state_e;

  if (DB_CYCLES < 2 || DB_CYCLES > 7) begin : g_bad_db_cycles
    $error("request_conditioner: DB_CYCLES must be in 2..7");
  end
  if ((DB_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("request_conditioner: CNT_W too narrow for DB_CYCLES-1");
  end
  if (EXPIRE_CYCLES < 1) begin : g_bad_expire
    $error("request_conditioner: EXPIRE_CYCLES must be at least 1");
  end

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  logic [NCH-1:0]   sync1_p0;
  logic [NCH-1:0]   sync2_p1;
  db_state_e        db_state_p2 [NCH];
  logic [CNT_W-1:0] db_cnt_p2   [NCH];
  logic [NPED-1:0]  ped_rise;
  logic [NVEH-1:0]  veh_lvl;
  logic [NPED-1:0]  ped_req_p3;
  logic [NPED-1:0]  press_p3;
  logic [NVEH-1:0]  veh_req_p3;

  // Stage p0/p1: two-flop synchroniser; channels 0..3 buttons, 4..5 sensors
  always_ff @(posedge clk_62) begin
    if (rst_62) begin
      sync1_p0 <= '0;
      sync2_p1 <= '0;
    end else begin
      sync1_p0 <= {bus.iraw_62, bus.braw_62};
      sync2_p1 <= sync1_p0;
    end
  end

  // Stage p2: per-channel debounce FSM on the synchronised level
  always_ff @(posedge clk_62) begin
    if (rst_62) begin
      for (int ch = 0; ch < NCH; ch++) begin
        db_state_p2[ch] <= LOW;
        db_cnt_p2[ch]   <= '0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        case (db_state_p2[ch])
          LOW: begin
            if (sync2_p1[ch]) begin
              db_state_p2[ch] <= RISE_CHK;
              db_cnt_p2[ch]   <= CNT_W'(1);
            end
          end
          RISE_CHK: begin
            if (!sync2_p1[ch]) begin
              db_state_p2[ch] <= LOW;
              db_cnt_p2[ch]   <= '0;
            end else if (db_cnt_p2[ch] == CNT_LAST) begin
              db_state_p2[ch] <= HIGH;
              db_cnt_p2[ch]   <= '0;
            end else begin
              db_cnt_p2[ch]   <= db_cnt_p2[ch] + CNT_W'(1);
            end
          end
          HIGH: begin
            if (!sync2_p1[ch]) begin
              db_state_p2[ch] <= FALL_CHK;
              db_cnt_p2[ch]   <= CNT_W'(1);
            end
          end
          FALL_CHK: begin
            if (sync2_p1[ch]) begin
              db_state_p2[ch] <= HIGH;
              db_cnt_p2[ch]   <= '0;
            end else if (db_cnt_p2[ch] == CNT_LAST) begin
              db_state_p2[ch] <= LOW;
              db_cnt_p2[ch]   <= '0;
            end else begin
              db_cnt_p2[ch]   <= db_cnt_p2[ch] + CNT_W'(1);
            end
          end
          default: begin
            db_state_p2[ch] <= LOW;
            db_cnt_p2[ch]   <= '0;
          end
        endcase
      end
    end
  end

  // The rise event fires on the edge that moves RISE_CHK into HIGH
  always_comb begin
    ped_rise = '0;
    for (int k = 0; k < NPED; k++) begin
      ped_rise[k] = (db_state_p2[k] == RISE_CHK) && sync2_p1[k] &&
                    (db_cnt_p2[k] == CNT_LAST);
    end
  end

  always_comb begin
    veh_lvl = '0;
    for (int d = 0; d < NVEH; d++) begin
      veh_lvl[d] = (db_state_p2[NPED+d] == HIGH) || (db_state_p2[NPED+d] == FALL_CHK);
    end
  end

  // Stage p3: sticky pedestrian requests; a walk on the same edge wins over a new press
  always_ff @(posedge clk_62) begin
    if (rst_62) begin
      ped_req_p3 <= '0;
      press_p3   <= '0;
    end else begin
      ped_req_p3 <= (ped_req_p3 | ped_rise) & ~bus.w_62;
      press_p3   <= ped_rise;
    end
  end

`ifdef REQ_EXPIRE_EN
  localparam int EXP_W = $clog2(EXPIRE_CYCLES + 1);
  localparam logic [EXP_W-1:0] EXP_LAST = EXP_W'(EXPIRE_CYCLES - 1);

  logic [EXP_W-1:0] exp_cnt_p3 [NVEH];
  logic [NVEH-1:0]  exp_run;
  logic [NVEH-1:0]  expire_hit;

  always_comb begin
    exp_run    = '0;
    expire_hit = '0;
    for (int d = 0; d < NVEH; d++) begin
      exp_run[d]    = veh_req_p3[d] && !veh_lvl[d] && !bus.g_62[d];
      expire_hit[d] = exp_run[d] && (exp_cnt_p3[d] == EXP_LAST);
    end
  end

  always_ff @(posedge clk_62) begin
    if (rst_62) begin
      for (int d = 0; d < NVEH; d++) exp_cnt_p3[d] <= '0;
    end else begin
      for (int d = 0; d < NVEH; d++) begin
        if (!exp_run[d] || expire_hit[d]) exp_cnt_p3[d] <= '0;
        else                              exp_cnt_p3[d] <= exp_cnt_p3[d] + EXP_W'(1);
      end
    end
  end
`endif

  // Vehicle requests follow the debounced level and are suppressed during green
  always_ff @(posedge clk_62) begin
    if (rst_62) begin
      veh_req_p3 <= '0;
    end else begin
      for (int d = 0; d < NVEH; d++) begin
        if (bus.g_62[d])     veh_req_p3[d] <= 1'b0;
        else if (veh_lvl[d]) veh_req_p3[d] <= 1'b1;
`ifdef REQ_EXPIRE_EN
        else if (expire_hit[d]) veh_req_p3[d] <= 1'b0;
`endif
      end
    end
  end

  assign bus.b_62        = ped_req_p3;
  assign bus.press_62    = press_p3;
  assign bus.i_62        = veh_req_p3;
  assign bus.pend_cnt_62 = popcount4(ped_req_p3);

endmodule

// File: tb/tb_request_conditioner.sv
// Directed-vector bench for request_conditioner with a queue-based scoreboard and a
// per-cycle monitor.
module tb_request_conditioner;

  logic clk_62 = 1'b0;
  logic rst_62;

  always #5 clk_62 = ~clk_62;

  request_conditioner_if bus ();

  request_conditioner #(
    .DB_CYCLES     (4),
    .CNT_W         (3),
    .EXPIRE_CYCLES (16)
  ) dut (
    .clk_62 (clk_62),
    .rst_62 (rst_62),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] b;
    logic [1:0] i;
    logic [3:0] press;
    logic [2:0] pend;
    logic       chk_i;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  // Drive one cycle of inputs and queue the outputs required after the next edge
  task automatic step(input logic [3:0] braw, input logic [1:0] iraw,
                      input logic [3:0] w, input logic [1:0] g, input logic rst,
                      input logic [3:0] eb, input logic [1:0] ei, input logic [3:0] ep,
                      input logic ci, input string tag);
    exp_t e;
    bus.braw_62 = braw;
    bus.iraw_62 = iraw;
    bus.w_62    = w;
    bus.g_62    = g;
    rst_62      = rst;
    e.b     = eb;
    e.i     = ei;
    e.press = ep;
    e.pend  = 3'($countones(eb));
    e.chk_i = ci;
    e.tag   = tag;
    sb.push_back(e);
    @(posedge clk_62);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk_62);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        n_vec++;
        if (bus.b_62 !== mon_e.b || bus.press_62 !== mon_e.press ||
            bus.pend_cnt_62 !== mon_e.pend || (mon_e.chk_i && bus.i_62 !== mon_e.i)) begin
          n_bad++;
          $display("FAIL %s: got b=%b i=%b press=%b pend=%0d, want b=%b i=%b press=%b pend=%0d",
                   mon_e.tag, bus.b_62, bus.i_62, bus.press_62, bus.pend_cnt_62,
                   mon_e.b, mon_e.i, mon_e.press, mon_e.pend);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors still queued", sb.size());
    $fatal(1, "watchdog");
  end

  logic [13:0] bounce;
  logic [1:0]  ei6;
  logic        ci6;

  initial begin
    bus.braw_62 = '0;
    bus.iraw_62 = '0;
    bus.w_62    = '0;
    bus.g_62    = '0;
    rst_62      = 1'b1;
    bounce      = 14'b11101010000000;

    // Reset with every raw input high, then requests appear 6 edges after release
    for (int j = 1; j <= 3; j++)
      step(4'hF, 2'b11, 4'h0, 2'b00, 1'b1, 4'h0, 2'b00, 4'h0, 1'b1, "reset_hold");
    for (int j = 1; j <= 7; j++)
      step(4'hF, 2'b11, 4'h0, 2'b00, 1'b0, (j >= 6) ? 4'hF : 4'h0,
           (j >= 7) ? 2'b11 : 2'b00, (j == 6) ? 4'hF : 4'h0, (j != 6), "post_reset");
    for (int j = 1; j <= 8; j++)
      step(4'h0, 2'b00, 4'hF, 2'b11, 1'b0, 4'h0, 2'b00, 4'h0, 1'b1, "serve_all");
    for (int j = 1; j <= 3; j++)
      step(4'h0, 2'b00, 4'h0, 2'b00, 1'b0, 4'h0, 2'b00, 4'h0, 1'b1, "idle_a");

    // Button 2 held 10 cycles then released: latched after the 6th edge, one press
    for (int j = 1; j <= 10; j++)
      step(4'b0010, 2'b00, 4'h0, 2'b00, 1'b0, (j >= 6) ? 4'b0010 : 4'b0000, 2'b00,
           (j == 6) ? 4'b0010 : 4'b0000, 1'b1, "btn2_hold");
    for (int j = 1; j <= 10; j++)
      step(4'h0, 2'b00, 4'h0, 2'b00, 1'b0, 4'b0010, 2'b00, 4'h0, 1'b1, "btn2_release");

    // Button 1: three cycles high then bouncing, never long enough to debounce
    for (int j = 0; j < 14; j++)
      step({3'b000, bounce[13-j]}, 2'b00, 4'h0, 2'b00, 1'b0, 4'b0010, 2'b00, 4'h0,
           1'b1, "btn1_bounce");

    // Button 4 makes b=1010, then walk 4 clears it alone
    for (int j = 1; j <= 6; j++)
      step(4'b1000, 2'b00, 4'h0, 2'b00, 1'b0, (j >= 6) ? 4'b1010 : 4'b0010, 2'b00,
           (j == 6) ? 4'b1000 : 4'b0000, 1'b1, "btn4_hold");
    for (int j = 1; j <= 6; j++)
      step(4'h0, 2'b00, 4'h0, 2'b00, 1'b0, 4'b1010, 2'b00, 4'h0, 1'b1, "btn4_release");
    step(4'h0, 2'b00, 4'b1000, 2'b00, 1'b0, 4'b0010, 2'b00, 4'h0, 1'b1, "walk4_clear");

    // Button 2 press completing on the same edge as walk 2: clear wins, press pulses
    for (int j = 1; j <= 10; j++)
      step(4'b0010, 2'b00, (j == 6) ? 4'b0010 : 4'b0000, 2'b00, 1'b0,
           (j >= 6) ? 4'b0000 : 4'b0010, 2'b00, (j == 6) ? 4'b0010 : 4'b0000,
           1'b1, "btn2_vs_walk");
    for (int j = 1; j <= 6; j++)
      step(4'h0, 2'b00, 4'h0, 2'b00, 1'b0, 4'h0, 2'b00, 4'h0, 1'b1, "btn2_release2");

    // Vehicle 1: latch, suppressed during green, re-asserts after green if present
    for (int j = 1; j <= 8; j++)
      step(4'h0, 2'b01, 4'h0, 2'b00, 1'b0, 4'h0, (j >= 7) ? 2'b01 : 2'b00, 4'h0,
           (j != 6), "veh1_arrive");
    for (int j = 1; j <= 4; j++)
      step(4'h0, 2'b01, 4'h0, 2'b01, 1'b0, 4'h0, 2'b00, 4'h0, 1'b1, "veh1_green");
    step(4'h0, 2'b01, 4'h0, 2'b00, 1'b0, 4'h0, 2'b01, 4'h0, 1'b1, "veh1_reassert");
    for (int j = 1; j <= 6; j++)
      step(4'h0, 2'b00, 4'h0, 2'b00, 1'b0, 4'h0, 2'b01, 4'h0, 1'b1, "veh1_release");
    step(4'h0, 2'b00, 4'h0, 2'b01, 1'b0, 4'h0, 2'b00, 4'h0, 1'b1, "veh1_served");
    for (int j = 1; j <= 2; j++)
      step(4'h0, 2'b00, 4'h0, 2'b00, 1'b0, 4'h0, 2'b00, 4'h0, 1'b1, "veh1_idle");

    // Vehicle 2: latch, then sensor low for 30 cycles without green
    for (int j = 1; j <= 8; j++)
      step(4'h0, 2'b10, 4'h0, 2'b00, 1'b0, 4'h0, (j >= 7) ? 2'b10 : 2'b00, 4'h0,
           (j != 6), "veh2_arrive");
    for (int r = 1; r <= 30; r++) begin
`ifdef REQ_EXPIRE_EN
      ei6 = (r >= 22) ? 2'b00 : 2'b10;
      ci6 = (r != 21);
`else
      ei6 = 2'b10;
      ci6 = 1'b1;
`endif
      step(4'h0, 2'b00, 4'h0, 2'b00, 1'b0, 4'h0, ei6, 4'h0, ci6, "veh2_expire");
    end

    repeat (3) @(negedge clk_62);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/request_conditioner.md
Name: request_conditioner

Overview:
- Upstream input stage for the traffic light controller.
- Synchronises and debounces the raw pedestrian buttons and vehicle loop sensors.
- Latches each debounced event as a sticky request and presents clean request levels to the controller's pedestrian and vehicle request inputs.
- Clears each request when the controller reports it has been served (walk or green feedback).

Parameters:
DB_CYCLES, 4, consecutive synchronised cycles an input must hold a new level before the debounced level changes (legal range 2..7).
CNT_W, 3, debounce counter width; must hold DB_CYCLES-1.
EXPIRE_CYCLES, 16, consecutive debounced-low cycles before a vehicle request expires (REQ_EXPIRE_EN only).

Ports:
clk_62  input  1  system clock, rising edge.
rst_62  input  1  reset; synchronous, active-high.
braw_62  input  4  raw pedestrian buttons; bit k = button k+1; asynchronous, may bounce.
iraw_62  input  2  raw vehicle sensors; bit d = direction d+1; asynchronous.
w_62  input  4  walk feedback from controller; bit k = w(k+1).
g_62  input  2  green feedback from controller; bit d = g(d+1).
b_62  output  4  latched pedestrian requests to controller (b1..b4).
i_62  output  2  latched vehicle requests to controller (i1, i2).
press_62  output  4  one-cycle pulse on each debounced pedestrian rising edge.
pend_cnt_62  output  3  popcount of b_62 (0..4).

Behaviour:
- Reset (sync, active-high): sync flops, debounce FSMs, counters, b_62, i_62 and press_62 all go to 0; pend_cnt_62 = 0.
  - Reset mid-debounce discards partial counts.
  - Reset has priority over every other event.
- Synchroniser: two flops per raw bit (6 channels). The debouncer sees s2.
- Debounce FSM, one per channel. States LOW, RISE_CHK, HIGH, FALL_CHK; 2-bit state plus CNT_W counter.
  - LOW: if s2=1, go to RISE_CHK with cnt=1.
  - RISE_CHK: if s2=0, go to LOW with cnt=0. Else if cnt=DB_CYCLES-1, go to HIGH and raise the rise event. Else cnt+1.
  - HIGH: if s2=1, stay. If s2=0, go to FALL_CHK with cnt=1.
  - FALL_CHK: if s2=1, go to HIGH with cnt=0. Else if cnt=DB_CYCLES-1, go to LOW. Else cnt+1.
  - Debounced level is 1 in HIGH and FALL_CHK.
  - A pulse or gap shorter than DB_CYCLES synchronised cycles produces no level change.
- Latency: raw held high from sampling edge E0 gives a rise event at edge E0+DB_CYCLES+1.
  - The request becomes visible after that edge: DB_CYCLES+2 edges including E0.
  - For DB_CYCLES=4, the request is visible after the 6th edge.
- Pedestrian request k:
  - Set on the rise event, and press_62[k]=1 for exactly that one cycle.
  - Cleared at any edge where w_62[k]=1.
  - Set and clear on the same edge: clear wins, and the press is discarded. press_62 still pulses.
  - Holding a button does not re-trigger; a new request needs a release of at least DB_CYCLES, then a new press.
- Vehicle request d:
  - Level-driven. At each edge, i_62[d] is set if the debounced level is 1 and g_62[d]=0.
  - i_62[d] is held 0 while g_62[d]=1.
  - After green drops, it re-asserts on the next edge if the vehicle is still debounced-present.
  - Once set, it is not cleared by sensor release (see optional feature).
- pend_cnt_62 is combinational popcount of the b_62 register; range 0..4, no overflow possible.
- All outputs are registered except pend_cnt_62.

Optional Feature:
REQ_EXPIRE_EN
- Defined: per direction, a counter runs while i_62[d]=1, the debounced level is 0, and g_62[d]=0. The counter resets to 0 whenever any of these conditions fails.
  - When the count reaches EXPIRE_CYCLES, i_62[d] clears at that edge and the counter resets.
  - Counter width is the bits needed for EXPIRE_CYCLES.
- Undefined: no counter is built; a vehicle request stays latched until green.

Test Plan:
1. All raw inputs 1, rst_62=1 for 3 edges -> b_62=0000, i_62=00, press_62=0000, pend_cnt_62=0 throughout reset. Requests appear DB_CYCLES+2 edges after rst_62 falls.
2. DB_CYCLES=4, braw_62[1] held 1 for 10 cycles then 0 -> b_62=0010 after the 6th edge, press_62[1] high exactly 1 cycle, pend_cnt_62=1. b_62 stays 0010 after release.
3. braw_62[0] high 3 cycles, then bouncing 1-0-1-0 per cycle -> b_62[0] and press_62[0] never assert.
4. b_62=1010, w_62[3]=1 for 1 cycle -> b_62=0010, pend_cnt_62=1. A press of button 2 completing while w_62[1]=1 -> b_62[1] stays 0 and press_62[1] pulses.
5. iraw_62[0]=1, g_62[0]=0 -> i_62[0]=1. Then g_62[0]=1 -> i_62[0]=0 on the next edge, held 0 while green. g_62[0]->0 with sensor still 1 -> i_62[0]=1 on the next edge.
6. iraw_62[1] pulsed long enough to latch, then 0 for 30 cycles, g_62=00, EXPIRE_CYCLES=16 -> with REQ_EXPIRE_EN, i_62[1] clears 16 edges after the debounced level falls. Without the macro, i_62[1] stays 1.
